// File: rtl/traffic_phase_arbiter.sv
// Demand-actuated green-phase scheduler for a 4-way intersection (N/W/S/E), round-robin with emergency preemption.
// Latency: a decision taken in a cycle takes effect on the next rising edge; lamps decode registered state only.
// Backpressure: none; car requests are latched until served, emergency requests must be held by their source.
module traffic_phase_arbiter #(
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 40,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] car_sense,
  input  logic [3:0] emerg_req,
  output logic [2:0] north_light,
  output logic [2:0] west_light,
  output logic [2:0] south_light,
  output logic [2:0] east_light,
  output logic [1:0] active_dir,
  output logic [1:0] phase,
  output logic       preempt_active
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_e;

  // Timer values at which each phase may end (timer counts from 0 at entry).
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] TIMER_SAT   = {CNT_W{1'b1}};

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       req_latch_q, req_latch_d;
  logic [1:0]       active_dir_q, active_dir_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic             preempt_q, preempt_d;

  logic [3:0]       active_mask;
  logic [3:0]       green_mask;
  logic [3:0]       pending;
  logic [3:0]       other_emerg;
  logic [CNT_W-1:0] timer_inc;
  logic [1:0]       emerg_idx;
  logic [1:0]       rr_idx;
  logic [1:0]       rr_cand;
  logic             rr_found;
  logic             grant;
  logic [2:0]       active_lamp;

  // State register: every piece of state, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ALL_RED;
      timer_q      <= '0;
      req_latch_q  <= 4'b0000;
      active_dir_q <= 2'd0;
      last_grant_q <= 2'd3;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      req_latch_q  <= req_latch_d;
      active_dir_q <= active_dir_d;
      last_grant_q <= last_grant_d;
      preempt_q    <= preempt_d;
    end
  end

  // Demand picture: pending requests (active green masked), lowest emergency, round-robin pick.
  always_comb begin
    active_mask = 4'b0001 << active_dir_q;
    green_mask  = (state_q == ST_GREEN) ? active_mask : 4'b0000;
    pending     = (req_latch_q | car_sense) & ~green_mask;
    other_emerg = emerg_req & ~active_mask;
    timer_inc   = (timer_q == TIMER_SAT) ? timer_q : timer_q + 1'b1;

    // Scan downward so the lowest-index requester is the last (winning) assignment.
    emerg_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (emerg_req[i]) emerg_idx = 2'(i);
    end

    // Search starts one past the last grant and wraps, so the last grantee is checked last.
    rr_found = 1'b0;
    rr_idx   = last_grant_q;
    rr_cand  = last_grant_q;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_grant_q + 2'(k);
      if (!rr_found && pending[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Next-state logic: phase sequencing, timer, grant bookkeeping and request latches.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_inc;
    active_dir_d = active_dir_q;
    last_grant_d = last_grant_q;
    preempt_d    = preempt_q;
    grant        = 1'b0;

    case (state_q)
      ST_ALL_RED: begin
        if (timer_q >= ALLRED_LAST) begin
          if (|emerg_req) begin
            grant        = 1'b1;
            active_dir_d = emerg_idx;
            preempt_d    = 1'b1;
          end else if (rr_found) begin
            grant        = 1'b1;
            active_dir_d = rr_idx;
            preempt_d    = 1'b0;
          end
        end
        if (grant) begin
          state_d      = ST_GREEN;
          timer_d      = '0;
          last_grant_d = active_dir_d;
        end
      end
      ST_GREEN: begin
        if (|other_emerg) begin
          state_d = ST_YELLOW;
          timer_d = '0;
        end else if (emerg_req[active_dir_q]) begin
          state_d = ST_GREEN;
        end else if ((timer_q >= MIN_LAST) && (|pending) &&
                     (!car_sense[active_dir_q] || (timer_q >= MAX_LAST))) begin
          state_d = ST_YELLOW;
          timer_d = '0;
        end
      end
      ST_YELLOW: begin
        if (timer_q >= YELLOW_LAST) begin
          state_d = ST_ALL_RED;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_ALL_RED;
        timer_d = '0;
      end
    endcase

    // Latch arrivals on non-green approaches; the approach being granted drops its latch.
    req_latch_d = req_latch_q | (car_sense & ~green_mask);
    if (grant) req_latch_d = req_latch_d & ~(4'b0001 << active_dir_d);
  end

  // Output decode from registered state only: one lamp bus may be non-red, the rest stay red.
  always_comb begin
    case (state_q)
      ST_GREEN:  active_lamp = LAMP_GREEN;
      ST_YELLOW: active_lamp = LAMP_YELLOW;
      default:   active_lamp = LAMP_RED;
    endcase
    north_light = LAMP_RED;
    west_light  = LAMP_RED;
    south_light = LAMP_RED;
    east_light  = LAMP_RED;
    case (active_dir_q)
      2'd0:    north_light = active_lamp;
      2'd1:    west_light  = active_lamp;
      2'd2:    south_light = active_lamp;
      default: east_light  = active_lamp;
    endcase
    active_dir     = active_dir_q;
    phase          = state_q;
    preempt_active = preempt_q;
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed bench for traffic_phase_arbiter with default timing (MIN 8, MAX 40, YELLOW 4, ALL-RED 2).
// A vector table covers reset, single request, gap-out, preemption and reset mid-yellow; hand sequences
// cover the full round-robin rotation timing and simultaneous emergency requests.
module tb_traffic_phase_arbiter;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk;
  logic       rst;
  logic [3:0] car_sense;
  logic [3:0] emerg_req;
  logic [2:0] north_light, west_light, south_light, east_light;
  logic [1:0] active_dir, phase;
  logic       preempt_active;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_phase_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .car_sense      (car_sense),
    .emerg_req      (emerg_req),
    .north_light    (north_light),
    .west_light     (west_light),
    .south_light    (south_light),
    .east_light     (east_light),
    .active_dir     (active_dir),
    .phase          (phase),
    .preempt_active (preempt_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] car;
    logic [3:0] em;
    int         n;
    logic [2:0] nl, wl, sl, el;
    logic [1:0] ph, dir;
    logic       pre;
    logic       chk_pre;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic [3:0] c, input logic [3:0] e, input int n,
                              input logic [2:0] nl, input logic [2:0] wl, input logic [2:0] sl,
                              input logic [2:0] el, input logic [1:0] ph, input logic [1:0] dr,
                              input logic pr, input logic cp);
    vec_t v;
    v.rst = r; v.car = c; v.em = e; v.n = n;
    v.nl = nl; v.wl = wl; v.sl = sl; v.el = el;
    v.ph = ph; v.dir = dr; v.pre = pr; v.chk_pre = cp;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts cycles spent in phase ph starting from the current sample (bounded).
  task automatic count_phase(input logic [1:0] ph, output int cnt);
    cnt = 0;
    while (phase == ph && cnt < 200) begin
      step(1);
      cnt++;
    end
  endtask

  task automatic wait_green(input string name);
    int cyc;
    cyc = 0;
    while (phase != 2'd1 && cyc < 20) begin
      step(1);
      cyc++;
    end
    chk(name, {31'd0, phase == 2'd1}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [16:0] act_v, exp_v;

    rst = 1'b1;
    car_sense = 4'b0000;
    emerg_req = 4'b0000;

    //  rst  car      em       n    N  W  S  E  ph    dir   pre  chk_pre
    add(1, 4'b0000, 4'b0000,  3,   R, R, R, R, 2'd0, 2'd0, 0, 1); // reset state
    add(0, 4'b0001, 4'b0000,  1,   R, R, R, R, 2'd0, 2'd0, 0, 1); // all-red clearance
    add(0, 4'b0001, 4'b0000,  1,   G, R, R, R, 2'd1, 2'd0, 0, 1); // N green at 2nd edge
    add(0, 4'b0001, 4'b0000, 60,   G, R, R, R, 2'd1, 2'd0, 0, 1); // uncontested rest
    add(1, 4'b0001, 4'b0000,  1,   R, R, R, R, 2'd0, 2'd0, 0, 1); // reset mid-green
    add(1, 4'b0000, 4'b0000,  2,   R, R, R, R, 2'd0, 2'd0, 0, 1); // reset held
    add(0, 4'b0001, 4'b0000,  2,   G, R, R, R, 2'd1, 2'd0, 0, 1); // gap-out: N green
    add(0, 4'b0001, 4'b0000,  2,   G, R, R, R, 2'd1, 2'd0, 0, 1);
    add(0, 4'b0100, 4'b0000,  1,   G, R, R, R, 2'd1, 2'd0, 0, 1); // N drops, S pulse
    add(0, 4'b0000, 4'b0000,  4,   G, R, R, R, 2'd1, 2'd0, 0, 1); // min green not met
    add(0, 4'b0000, 4'b0000,  1,   Y, R, R, R, 2'd2, 2'd0, 0, 1); // yellow after 8 green
    add(0, 4'b0000, 4'b0000,  3,   Y, R, R, R, 2'd2, 2'd0, 0, 1);
    add(0, 4'b0000, 4'b0000,  1,   R, R, R, R, 2'd0, 2'd0, 0, 1); // yellow was 4 cycles
    add(0, 4'b0000, 4'b0000,  1,   R, R, R, R, 2'd0, 2'd0, 0, 1);
    add(0, 4'b0000, 4'b0000,  1,   R, R, G, R, 2'd1, 2'd2, 0, 1); // S green, W skipped
    add(1, 4'b0000, 4'b0000,  1,   R, R, R, R, 2'd0, 2'd0, 0, 1);
    add(0, 4'b0001, 4'b0000,  2,   G, R, R, R, 2'd1, 2'd0, 0, 1); // preempt: N green
    add(0, 4'b0001, 4'b0000,  2,   G, R, R, R, 2'd1, 2'd0, 0, 1); // timer = 2
    add(0, 4'b0001, 4'b1000,  1,   Y, R, R, R, 2'd2, 2'd0, 0, 1); // yellow next edge
    add(0, 4'b0001, 4'b1000,  4,   R, R, R, R, 2'd0, 2'd0, 0, 1);
    add(0, 4'b0001, 4'b1000,  2,   R, R, R, G, 2'd1, 2'd3, 1, 1); // E preempt green
    add(0, 4'b0001, 4'b1000, 50,   R, R, R, G, 2'd1, 2'd3, 1, 1); // held past MAX
    add(0, 4'b0001, 4'b0000,  1,   R, R, R, Y, 2'd2, 2'd3, 0, 0); // release: E yellow
    add(0, 4'b0001, 4'b0000,  6,   G, R, R, R, 2'd1, 2'd0, 0, 1); // N normal green
    add(0, 4'b0001, 4'b0010,  1,   Y, R, R, R, 2'd2, 2'd0, 0, 1); // W emergency cuts N
    add(1, 4'b0000, 4'b0000,  1,   R, R, R, R, 2'd0, 2'd0, 0, 1); // reset mid-yellow

    foreach (vq[i]) begin
      rst       = vq[i].rst;
      car_sense = vq[i].car;
      emerg_req = vq[i].em;
      step(vq[i].n);
      act_v = {north_light, west_light, south_light, east_light, phase, active_dir,
               vq[i].chk_pre ? preempt_active : 1'b0};
      exp_v = {vq[i].nl, vq[i].wl, vq[i].sl, vq[i].el, vq[i].ph, vq[i].dir,
               vq[i].chk_pre ? vq[i].pre : 1'b0};
      n_assert++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL vec%0d: got N=%b W=%b S=%b E=%b ph=%0d dir=%0d pre=%b, expected N=%b W=%b S=%b E=%b ph=%0d dir=%0d pre=%b",
                 i, act_v[16:14], act_v[13:11], act_v[10:8], act_v[7:5], act_v[4:3], act_v[2:1], act_v[0],
                 exp_v[16:14], exp_v[13:11], exp_v[10:8], exp_v[7:5], exp_v[4:3], exp_v[2:1], exp_v[0]);
      end
    end

    // Round-robin with all approaches contested: N, W, S, E, N; 40/4/2 each.
    rst = 1'b1;
    car_sense = 4'b0000;
    emerg_req = 4'b0000;
    step(1);
    rst = 1'b0;
    car_sense = 4'b1111;
    wait_green("rr_first_green");
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rr_dir%0d", d), {30'd0, active_dir}, d);
      count_phase(2'd1, cnt);
      chk($sformatf("rr_green_len%0d", d), cnt, 32'd40);
      count_phase(2'd2, cnt);
      chk($sformatf("rr_yellow_len%0d", d), cnt, 32'd4);
      count_phase(2'd0, cnt);
      chk($sformatf("rr_allred_len%0d", d), cnt, 32'd2);
    end
    chk("rr_wrap_dir", {30'd0, active_dir}, 32'd0);
    chk("rr_wrap_north", {29'd0, north_light}, {29'd0, G});

    // Simultaneous emergencies W and S: W first, S after W yields.
    rst = 1'b1;
    car_sense = 4'b0000;
    emerg_req = 4'b0000;
    step(1);
    rst = 1'b0;
    emerg_req = 4'b0110;
    wait_green("em_first_green");
    chk("em_first_dir", {30'd0, active_dir}, 32'd1);
    chk("em_first_pre", {31'd0, preempt_active}, 32'd1);
    chk("em_first_west", {29'd0, west_light}, {29'd0, G});
    emerg_req = 4'b0100;
    count_phase(2'd1, cnt);
    chk("em_w_green_len", cnt, 32'd1);
    count_phase(2'd2, cnt);
    chk("em_w_yellow_len", cnt, 32'd4);
    count_phase(2'd0, cnt);
    chk("em_w_allred_len", cnt, 32'd2);
    chk("em_second_dir", {30'd0, active_dir}, 32'd2);
    chk("em_second_pre", {31'd0, preempt_active}, 32'd1);
    chk("em_second_south", {29'd0, south_light}, {29'd0, G});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
